shadow_pattern_src: RTL
=======================

SHADOW_PATTERN_SRC -- requirements
Module: shadow_pattern_src

Interface
REQ-001 Parameter CHAINS, default 10, number of independent pattern chains (1..128).
REQ-002 Parameter DEPTH, default 8, words emitted per chain per run (2..256).
REQ-003 Parameter SEED, default 16'hACE1, base LFSR seed.
REQ-004 rclk  input  1  single clock; all state on rising edge.
REQ-005 arst_l  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  run request, sampled in IDLE only.
REQ-007 abort  input  1  terminate run, return to IDLE.
REQ-008 mode  input  2  pattern select, latched at start: 0 ONES, 1 WALK, 2 CNT, 3 LFSR.
REQ-009 chain_dump_en  input  CHAINS  per-chain advance enable; 0 = stall that chain.
REQ-010 err_en  input  1  error injection enable.
REQ-011 err_ctrl  input  7  index of chain whose output bit is inverted.
REQ-012 chains_out  output  CHAINS  pattern bit per chain.
REQ-013 chains_out_vld  output  CHAINS  chain bit valid.
REQ-014 chains_out_done  output  CHAINS  chain finished its DEPTH words.
REQ-015 busy  output  1  high in RUN and DONE.

Function
REQ-016 FSM states IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE on the edge where the last unfinished chain finishes; DONE->IDLE after exactly one cycle; abort forces ->IDLE from any state.
REQ-017 start sampled on edge E puts the FSM in RUN from E+1 with every lane cnt=0, finished=0, mode latched; start in RUN/DONE ignored; abort wins over start.
REQ-018 Per lane i in RUN: vld[i]=~finished[i]; cnt[i] advances by 1 on an edge where vld[i] and chain_dump_en[i]; advance from cnt=DEPTH-1 sets finished[i] instead of wrapping.
REQ-019 chains_out_done[i]=finished[i] in RUN and DONE, 0 in IDLE; chains_out and vld are 0 whenever vld[i]=0.
REQ-020 ONES: bit=1. WALK: bit=(cnt[i]==i mod DEPTH). CNT: bit=cnt[i][i mod CW], CW=clog2(DEPTH).
REQ-021 LFSR: lane i lfsr loaded at start with SEED^i (value 0 replaced by 16'h0001); bit=lfsr[0]; on each advance lfsr=(lfsr>>1)^(lfsr[0]?16'hB400:0).
REQ-022 Injection: when err_en and err_ctrl<CHAINS and vld[err_ctrl], chains_out[err_ctrl] is inverted; err_ctrl>=CHAINS has no effect; injection never alters cnt, lfsr or vld.
REQ-023 All outputs except the injection XOR derive from registers only; latency start->first valid bit is 1 cycle.
REQ-024 Stalled lanes hold cnt, lfsr, vld and chains_out unchanged indefinitely.

Reset
REQ-025 arst_l low asynchronously forces IDLE, all cnt=0, finished=0, lfsr=0, latched mode=ONES; all outputs 0, busy 0.
REQ-026 Reset mid-run discards the run; no done is produced; first start after release behaves as from power-up.

Structure
REQ-027 Shared package shadow_pkg holds mode encodings, FSM state encoding, LFSR polynomial 16'hB400 and zero-seed substitute.
REQ-028 One sub-module shadow_pattern_lane (cnt, lfsr, finished, bit generation) instantiated CHAINS times via generate; top holds FSM, all-finished reduction, injection.

Verification (CHAINS=10, DEPTH=8)
REQ-029 ONES, dump_en=3FF, start at edge 0 -> out=vld=3FF cycles 1..8; cycle 9 DONE, done=3FF, busy=1; cycle 10 busy=0, done=000.
REQ-030 WALK, dump_en=3FF -> out cycle1=0x101, cycle2=0x202, cycle3=0x004, cycle8=0x080.
REQ-031 ONES, dump_en[3]=0 cycles 1..4 -> done[3] at cycle 13 while others done from cycle 9; DONE state cycle 13, IDLE cycle 14.
REQ-032 LFSR, SEED=ACE1 -> chain0 bits 1,0 (ACE1->E270); chain1 seed ACE0 first bit 0; err_en=1, err_ctrl=0 inverts chain0 only; err_ctrl=12 no change.
REQ-033 abort at cycle 4 -> IDLE cycle 5, all outputs 0, no done; arst_l low at cycle 4 -> same, asynchronously; later start runs full 8 words.

Source files
------------

// File: rtl/shadow_pkg.sv
// Shared types and constants for the shadow pattern source: mode and FSM
// encodings, LFSR feedback polynomial and the per-lane seed helper.
package shadow_pkg;

  typedef enum logic [1:0] {
    MODE_ONES = 2'd0,
    MODE_WALK = 2'd1,
    MODE_CNT  = 2'd2,
    MODE_LFSR = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [15:0] LFSR_POLY = 16'hB400;
  localparam logic [15:0] LFSR_ZERO_SUB = 16'h0001;

  // An all-zero Galois LFSR would lock up, so a zero seed is substituted.
  function automatic logic [15:0] lane_seed(input logic [15:0] base, input int unsigned idx);
    logic [15:0] s;
    s = base ^ 16'(idx);
    return (s == 16'h0000) ? LFSR_ZERO_SUB : s;
  endfunction

endpackage

// File: rtl/shadow_pattern_lane.sv
// One pattern chain: word counter, LFSR, finished flag and bit generation.
module shadow_pattern_lane
  import shadow_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned IDX   = 0,
  parameter logic [15:0] SEED  = 16'hACE1
) (
  input  logic  rclk,
  input  logic  arst_l,
  input  logic  load,
  input  logic  run,
  input  mode_e mode,
  input  logic  dump_en,
  output logic  pat,
  output logic  vld,
  output logic  finished,
  output logic  fin_nxt
);

  localparam int unsigned CW   = $clog2(DEPTH);
  localparam int unsigned WI   = IDX % DEPTH;
  localparam int unsigned CB   = IDX % CW;
  localparam logic [CW-1:0] LAST   = CW'(DEPTH - 1);
  localparam logic [CW-1:0] WALK_AT = CW'(WI);
  localparam logic [15:0] LANE_SEED = lane_seed(SEED, IDX);

  logic [CW-1:0] cnt;
  logic [15:0]   lfsr;
  logic          adv;
  logic          raw;

  assign vld     = run & ~finished;
  assign adv     = vld & dump_en;
  assign fin_nxt = finished | (adv & (cnt == LAST));

  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      cnt      <= '0;
      finished <= 1'b0;
      lfsr     <= '0;
    end else if (load) begin
      cnt      <= '0;
      finished <= 1'b0;
      lfsr     <= LANE_SEED;
    end else if (adv) begin
      if (cnt == LAST) finished <= 1'b1;
      else             cnt      <= cnt + 1'b1;
      lfsr <= (lfsr >> 1) ^ (lfsr[0] ? LFSR_POLY : 16'h0000);
    end
  end

  always_comb begin
    raw = 1'b0;
    unique case (mode)
      MODE_ONES: raw = 1'b1;
      MODE_WALK: raw = (cnt == WALK_AT);
      MODE_CNT:  raw = cnt[CB];
      MODE_LFSR: raw = lfsr[0];
      default:   raw = 1'b0;
    endcase
  end

  assign pat = vld & raw;

endmodule

// File: rtl/shadow_pattern_src.sv
// Multi-chain test pattern source: run FSM, per-chain lanes and single-chain
// error injection on the output bit.
module shadow_pattern_src
  import shadow_pkg::*;
#(
  parameter int unsigned CHAINS = 10,
  parameter int unsigned DEPTH  = 8,
  parameter logic [15:0] SEED   = 16'hACE1
) (
  input  logic              rclk,
  input  logic              arst_l,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        mode,
  input  logic [CHAINS-1:0] chain_dump_en,
  input  logic              err_en,
  input  logic [6:0]        err_ctrl,
  output logic [CHAINS-1:0] chains_out,
  output logic [CHAINS-1:0] chains_out_vld,
  output logic [CHAINS-1:0] chains_out_done,
  output logic              busy
);

  state_e state, state_nxt;
  mode_e  mode_q;

  logic              run, load, active;
  logic [CHAINS-1:0] pat, vld, fin, fin_nxt, inj;

  assign load = (state == ST_IDLE) & start & ~abort;

  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      state  <= ST_IDLE;
      mode_q <= MODE_ONES;
    end else begin
      state <= state_nxt;
      if (load) mode_q <= mode_e'(mode);
    end
  end

  // RUN ends on the edge where the last lane finishes, hence fin_nxt.
  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: if (start)     state_nxt = ST_RUN;
        ST_RUN:  if (&fin_nxt)  state_nxt = ST_DONE;
        ST_DONE:                state_nxt = ST_IDLE;
        default:                state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    run    = (state == ST_RUN);
    active = (state == ST_RUN) || (state == ST_DONE);
    busy   = active;
  end

  for (genvar g = 0; g < CHAINS; g++) begin : g_lane
    shadow_pattern_lane #(
      .DEPTH (DEPTH),
      .IDX   (g),
      .SEED  (SEED)
    ) u_lane (
      .rclk     (rclk),
      .arst_l   (arst_l),
      .load     (load),
      .run      (run),
      .mode     (mode_q),
      .dump_en  (chain_dump_en[g]),
      .pat      (pat[g]),
      .vld      (vld[g]),
      .finished (fin[g]),
      .fin_nxt  (fin_nxt[g])
    );
  end

  always_comb begin
    inj = '0;
    for (int unsigned i = 0; i < CHAINS; i++) begin
      if (err_en && (err_ctrl == 7'(i))) inj[i] = vld[i];
    end
  end

  assign chains_out      = pat ^ inj;
  assign chains_out_vld  = vld;
  assign chains_out_done = active ? fin : '0;

endmodule
